// File: rtl/tcp_rt_pkg.sv
// Shared types for the TCP retransmit timer table: command opcodes, event reasons,
// ACK number width and the modular (wrap-safe) ACK comparison.
package tcp_rt_pkg;

  // Same width as the SoC-wide ACK/sequence number.
  localparam int ACK_NUM_W = 32;

  typedef enum logic [1:0] {
    RT_OP_INIT   = 2'd0,
    RT_OP_ARM    = 2'd1,
    RT_OP_DISARM = 2'd2,
    RT_OP_ACK    = 2'd3
  } rt_cmd_op_e;

  typedef enum logic {
    RT_RSN_TIMEOUT = 1'b0,
    RT_RSN_FAST    = 1'b1
  } rt_evt_reason_e;

  typedef enum logic [1:0] {
    RT_ACK_STALE = 2'd0,
    RT_ACK_DUP   = 2'd1,
    RT_ACK_NEW   = 2'd2
  } rt_ack_cls_e;

  // The difference is read as signed so that ACK numbers compare correctly across wrap.
  function automatic rt_ack_cls_e rt_ack_classify(input logic [ACK_NUM_W-1:0] rx_ack,
                                                  input logic [ACK_NUM_W-1:0] cur_ack);
    logic [ACK_NUM_W-1:0] diff;
    diff = rx_ack - cur_ack;
    if (diff == '0) begin
      return RT_ACK_DUP;
    end else if (diff[ACK_NUM_W-1]) begin
      return RT_ACK_STALE;
    end
    return RT_ACK_NEW;
  endfunction

endpackage

// File: rtl/tcp_rt_scanner.sv
// Round-robin expiry scanner: visits one flow per cycle, fire is combinational from the pointed slot.
// A blocked expired slot parks the pointer; non-expired slots are always stepped over.
module tcp_rt_scanner
  import tcp_rt_pkg::*;
#(
  parameter int NUM_FLOWS   = 16,
  parameter int FLOWID_W    = $clog2(NUM_FLOWS),
  parameter int TIMESTAMP_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TIMESTAMP_W-1:0] now_i,
  input  logic                   cur_armed_i,
  input  logic [TIMESTAMP_W-1:0] cur_deadline_i,
  input  logic                   evt_blocked_i,
  input  logic                   cmd_evt_i,
  input  logic                   cmd_acc_i,
  input  logic [FLOWID_W-1:0]    cmd_flowid_i,
  output logic [FLOWID_W-1:0]    ptr_o,
  output logic                   fire_o
);

  localparam logic [FLOWID_W-1:0] LAST_FLOW = FLOWID_W'(NUM_FLOWS - 1);

  logic [FLOWID_W-1:0]    ptr_q, ptr_d;
  logic [TIMESTAMP_W-1:0] age;
  logic                   expired;
  logic                   hold;

  always_comb begin
    age     = now_i - cur_deadline_i;
    expired = cur_armed_i & ~age[TIMESTAMP_W-1];
    // Parking only matters on an expired slot, so the pointer waits on the next pending expiry.
    hold    = expired & (evt_blocked_i | cmd_evt_i | (cmd_acc_i & (cmd_flowid_i == ptr_q)));
    fire_o  = expired & ~hold;
    ptr_d   = ptr_q;
    if (!hold) begin
      ptr_d = (ptr_q == LAST_FLOW) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/tcp_rt_timer_table.sv
// Per-flow TCP retransmit timers and dup-ACK counters; events are registered (cmd or expiry in N -> evt_val in N+1).
// Single event slot; cmd_rdy drops while the slot is full and not draining.
module tcp_rt_timer_table
  import tcp_rt_pkg::*;
#(
  parameter int          NUM_FLOWS         = 16,
  parameter int          FLOWID_W          = $clog2(NUM_FLOWS),
  parameter int          TIMESTAMP_W       = 64,
  parameter int unsigned RT_TIMEOUT_CYCLES = 250000000,
  parameter int          DUP_ACK_CNT_W     = 4,
  parameter int          DUP_ACK_RT        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_val,
  output logic                   cmd_rdy,
  input  logic [1:0]             cmd_op,
  input  logic [FLOWID_W-1:0]    cmd_flowid,
  input  logic [ACK_NUM_W-1:0]   cmd_ack_num,
  output logic                   evt_val,
  input  logic                   evt_rdy,
  output logic [FLOWID_W-1:0]    evt_flowid,
  output logic                   evt_reason,
  output logic [TIMESTAMP_W-1:0] now
);

  localparam logic [TIMESTAMP_W-1:0]   RT_TIMEOUT = TIMESTAMP_W'(RT_TIMEOUT_CYCLES);
  localparam logic [DUP_ACK_CNT_W-1:0] DUP_MAX    = '1;
  localparam logic [DUP_ACK_CNT_W-1:0] DUP_TRIG   = DUP_ACK_CNT_W'(DUP_ACK_RT);

  typedef struct packed {
    logic [ACK_NUM_W-1:0]     ack_num;
    logic [DUP_ACK_CNT_W-1:0] dup_cnt;
  } ack_state_struct;

  typedef struct packed {
    logic                   armed;
    logic [TIMESTAMP_W-1:0] deadline;
  } tx_ack_timer_struct;

  typedef struct packed {
    ack_state_struct    ack;
    tx_ack_timer_struct tmr;
  } rt_flow_state_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    rt_evt_reason_e      reason;
  } rt_evt_struct;

  rt_flow_state_struct tbl_q [NUM_FLOWS];
  rt_flow_state_struct tbl_d [NUM_FLOWS];

  logic [TIMESTAMP_W-1:0]   now_q;
  logic [TIMESTAMP_W-1:0]   rearm_deadline;
  logic                     evt_vld_q, evt_vld_d;
  rt_evt_struct             evt_q, evt_d;
  rt_cmd_op_e               op;
  rt_ack_cls_e              ack_cls;
  ack_state_struct          cur_ack;
  logic                     cur_armed;
  logic [DUP_ACK_CNT_W-1:0] dup_inc;
  logic                     dup_hit;
  logic                     cmd_acc;
  logic                     cmd_evt;
  logic                     evt_blocked;
  logic [FLOWID_W-1:0]      scan_ptr;
  logic                     scan_fire;
  tx_ack_timer_struct       scan_tmr;

  assign op             = rt_cmd_op_e'(cmd_op);
  assign cmd_rdy        = ~evt_vld_q | evt_rdy;
  assign cmd_acc        = cmd_val & cmd_rdy;
  assign evt_blocked    = evt_vld_q & ~evt_rdy;
  assign rearm_deadline = now_q + RT_TIMEOUT;

  assign cur_ack   = tbl_q[cmd_flowid].ack;
  assign cur_armed = tbl_q[cmd_flowid].tmr.armed;
  assign ack_cls   = rt_ack_classify(cmd_ack_num, cur_ack.ack_num);
  assign dup_inc   = (cur_ack.dup_cnt == DUP_MAX) ? DUP_MAX : cur_ack.dup_cnt + 1'b1;
  // A saturated counter never re-triggers, even when the threshold equals all-ones.
  assign dup_hit   = (cur_ack.dup_cnt != DUP_MAX) && (dup_inc == DUP_TRIG);
  assign cmd_evt   = cmd_acc && (op == RT_OP_ACK) && (ack_cls == RT_ACK_DUP) && dup_hit;

  assign scan_tmr = tbl_q[scan_ptr].tmr;

  tcp_rt_scanner #(
    .NUM_FLOWS   (NUM_FLOWS),
    .FLOWID_W    (FLOWID_W),
    .TIMESTAMP_W (TIMESTAMP_W)
  ) u_scanner (
    .clk            (clk),
    .rst            (rst),
    .now_i          (now_q),
    .cur_armed_i    (scan_tmr.armed),
    .cur_deadline_i (scan_tmr.deadline),
    .evt_blocked_i  (evt_blocked),
    .cmd_evt_i      (cmd_evt),
    .cmd_acc_i      (cmd_acc),
    .cmd_flowid_i   (cmd_flowid),
    .ptr_o          (scan_ptr),
    .fire_o         (scan_fire)
  );

  always_comb begin
    tbl_d = tbl_q;
    if (scan_fire) begin
      tbl_d[scan_ptr].tmr.armed = 1'b0;
    end
    if (cmd_acc) begin
      case (op)
        RT_OP_INIT: begin
          tbl_d[cmd_flowid].ack.ack_num = cmd_ack_num;
          tbl_d[cmd_flowid].ack.dup_cnt = '0;
          tbl_d[cmd_flowid].tmr.armed   = 1'b0;
        end
        RT_OP_ARM: begin
          tbl_d[cmd_flowid].tmr.armed    = 1'b1;
          tbl_d[cmd_flowid].tmr.deadline = rearm_deadline;
        end
        RT_OP_DISARM: begin
          tbl_d[cmd_flowid].tmr.armed = 1'b0;
        end
        RT_OP_ACK: begin
          case (ack_cls)
            RT_ACK_NEW: begin
              tbl_d[cmd_flowid].ack.ack_num = cmd_ack_num;
              tbl_d[cmd_flowid].ack.dup_cnt = '0;
              if (cur_armed) begin
                tbl_d[cmd_flowid].tmr.deadline = rearm_deadline;
              end
            end
            RT_ACK_DUP: begin
              tbl_d[cmd_flowid].ack.dup_cnt = dup_inc;
              if (dup_hit) begin
                tbl_d[cmd_flowid].tmr.armed    = 1'b1;
                tbl_d[cmd_flowid].tmr.deadline = rearm_deadline;
              end
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    evt_vld_d = evt_vld_q & ~evt_rdy;
    evt_d     = evt_q;
    if (cmd_evt) begin
      evt_vld_d    = 1'b1;
      evt_d.flowid = cmd_flowid;
      evt_d.reason = RT_RSN_FAST;
    end else if (scan_fire) begin
      evt_vld_d    = 1'b1;
      evt_d.flowid = scan_ptr;
      evt_d.reason = RT_RSN_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q     <= '0;
      evt_vld_q <= 1'b0;
      evt_q     <= '0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      now_q     <= now_q + 1'b1;
      evt_vld_q <= evt_vld_d;
      evt_q     <= evt_d;
      tbl_q     <= tbl_d;
    end
  end

  assign evt_val    = evt_vld_q;
  assign evt_flowid = evt_q.flowid;
  assign evt_reason = evt_q.reason;
  assign now        = now_q;

endmodule

// File: tb/tb_tcp_rt_timer_table.sv
// Directed bench for tcp_rt_timer_table: 4 flows, 100-cycle timeout, fast retransmit on the 3rd dup ACK.
module tb_tcp_rt_timer_table;
  import tcp_rt_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_val = 1'b0;
  logic                 cmd_rdy;
  logic [1:0]           cmd_op = 2'd0;
  logic [1:0]           cmd_flowid = 2'd0;
  logic [ACK_NUM_W-1:0] cmd_ack_num = '0;
  logic                 evt_val;
  logic                 evt_rdy = 1'b1;
  logic [1:0]           evt_flowid;
  logic                 evt_reason;
  logic [63:0]          now;

  typedef struct packed {
    logic [3:0]  flow;
    logic        rsn;
    logic [63:0] t;
  } ev_t;

  ev_t         evq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] acc_now;

  tcp_rt_timer_table #(
    .NUM_FLOWS         (4),
    .FLOWID_W          (2),
    .TIMESTAMP_W       (64),
    .RT_TIMEOUT_CYCLES (100),
    .DUP_ACK_CNT_W     (4),
    .DUP_ACK_RT        (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_val     (cmd_val),
    .cmd_rdy     (cmd_rdy),
    .cmd_op      (cmd_op),
    .cmd_flowid  (cmd_flowid),
    .cmd_ack_num (cmd_ack_num),
    .evt_val     (evt_val),
    .evt_rdy     (evt_rdy),
    .evt_flowid  (evt_flowid),
    .evt_reason  (evt_reason),
    .now         (now)
  );

  always #5 clk = ~clk;

  // Every consumed event is logged with the time value of the cycle it was consumed in.
  always @(negedge clk) begin
    if (!rst && evt_val && evt_rdy) begin
      evq.push_back('{flow: {2'b00, evt_flowid}, rsn: evt_reason, t: now});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t ev_at(input int k);
    ev_t e;
    e = '{flow: 4'hf, rsn: 1'b1, t: '1};
    if (k < evq.size()) e = evq[k];
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the edge following acceptance.
  task automatic cmd(input logic [1:0] op, input logic [1:0] fl, input logic [31:0] ack);
    int n;
    cmd_val = 1'b1; cmd_op = op; cmd_flowid = fl; cmd_ack_num = ack;
    n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) check("cmd_accept_timeout", 64'(cmd_rdy), 64'd1);
    acc_now = now;
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
  endtask

  task automatic wait_now(input logic [63:0] t);
    int n;
    n = 0;
    while (now < t && n < 2000) begin
      tick(1);
      n++;
    end
    if (now != t) check("wait_now", now, t);
  endtask

  task automatic wait_evt(input int base, input int budget);
    int n;
    n = 0;
    while (evq.size() <= base && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    logic [63:0] t_arm, t_ack, d;
    logic [1:0]  first;
    int          base, unstable, fast, hiv;
    ev_t         e0, e1;

    // Reset values
    tick(3);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_evt_val", evt_val, 0);
    check("rst_evt_flowid", evt_flowid, 0);
    check("rst_evt_reason", evt_reason, 0);
    check("rst_now", now, 0);
    rst = 1'b0;

    // Single timeout on flow 2, armed at now=10
    cmd(RT_OP_INIT, 2'd2, 32'd1000);
    check("now_count", now, 1);
    wait_now(64'd10);
    cmd(RT_OP_ARM, 2'd2, 32'd0);
    wait_evt(0, 300);
    e0 = ev_at(0);
    check("p1_evt_cnt", 64'(evq.size()), 1);
    check("p1_flow", e0.flow, 2);
    check("p1_reason", e0.rsn, 0);
    check("p1_window", 64'(e0.t >= 111 && e0.t <= 115), 1);
    tick(150);
    check("p1_no_repeat", 64'(evq.size()), 1);

    // Fast retransmit on the third dup ACK; later dups saturate silently
    cmd(RT_OP_INIT, 2'd1, 32'd500);
    cmd(RT_OP_ARM, 2'd1, 32'd0);
    base = evq.size();
    cmd(RT_OP_ACK, 2'd1, 32'd500);
    check("p2_dup1_val", evt_val, 0);
    cmd(RT_OP_ACK, 2'd1, 32'd500);
    check("p2_dup2_val", evt_val, 0);
    cmd(RT_OP_ACK, 2'd1, 32'd500);
    check("p2_dup3_val", evt_val, 1);
    check("p2_dup3_flow", evt_flowid, 1);
    check("p2_dup3_reason", evt_reason, 1);
    cmd(RT_OP_ACK, 2'd1, 32'd500);
    check("p2_dup4_val", evt_val, 0);
    cmd(RT_OP_ACK, 2'd1, 32'd500);
    check("p2_dup5_val", evt_val, 0);
    for (int i = 0; i < 15; i++) cmd(RT_OP_ACK, 2'd1, 32'd500);
    tick(2);
    fast = 0;
    for (int i = base; i < evq.size(); i++) if (evq[i].rsn) fast++;
    check("p2_fast_once", 64'(fast), 1);
    check("p2_evt_total", 64'(evq.size() - base), 1);
    cmd(RT_OP_DISARM, 2'd1, 32'd0);

    // New ACK clears dup count and restarts the timer; a stale ACK is ignored
    cmd(RT_OP_INIT, 2'd1, 32'd500);
    cmd(RT_OP_ARM, 2'd1, 32'd0);
    t_arm = acc_now;
    cmd(RT_OP_ACK, 2'd1, 32'd500);
    cmd(RT_OP_ACK, 2'd1, 32'd500);
    check("p3_dup2_val", evt_val, 0);
    wait_now(t_arm + 50);
    cmd(RT_OP_ACK, 2'd1, 32'd600);
    t_ack = acc_now;
    cmd(RT_OP_ACK, 2'd1, 32'd400);
    check("p3_stale_val", evt_val, 0);
    base = evq.size();
    wait_now(t_arm + 120);
    check("p3_old_deadline", 64'(evq.size()), 64'(base));
    wait_evt(base, 100);
    e0 = ev_at(base);
    d = e0.t - t_ack;
    check("p3_rearm_flow", e0.flow, 1);
    check("p3_rearm_reason", e0.rsn, 0);
    check("p3_rearm_window", 64'(d >= 101 && d <= 105), 1);
    for (int i = 0; i < 3; i++) begin
      cmd(RT_OP_ACK, 2'd1, 32'd600);
      check("p3_dup_after_new", evt_val, 64'(i == 2));
    end
    cmd(RT_OP_DISARM, 2'd1, 32'd0);

    // ACK number wrap: 0xFFFFFFF0 -> 0x10 is new, 0x10 -> 0xFFFFFFF0 is stale
    cmd(RT_OP_INIT, 2'd0, 32'hFFFF_FFF0);
    cmd(RT_OP_ACK, 2'd0, 32'h0000_0010);
    check("p4_wrap_new_val", evt_val, 0);
    for (int i = 0; i < 3; i++) begin
      cmd(RT_OP_ACK, 2'd0, 32'h0000_0010);
      check("p4_wrap_new_dup", evt_val, 64'(i == 2));
    end
    check("p4_wrap_new_flow", evt_flowid, 0);
    cmd(RT_OP_DISARM, 2'd0, 32'd0);
    cmd(RT_OP_INIT, 2'd0, 32'h0000_0010);
    cmd(RT_OP_ACK, 2'd0, 32'hFFFF_FFF0);
    check("p4_wrap_stale_val", evt_val, 0);
    for (int i = 0; i < 3; i++) begin
      cmd(RT_OP_ACK, 2'd0, 32'h0000_0010);
      check("p4_wrap_stale_dup", evt_val, 64'(i == 2));
    end
    cmd(RT_OP_DISARM, 2'd0, 32'd0);
    tick(2);

    // Flows 0 and 3 expire together while the consumer stalls
    cmd(RT_OP_ARM, 2'd0, 32'd0);
    t_arm = acc_now;
    cmd(RT_OP_ARM, 2'd3, 32'd0);
    evt_rdy = 1'b0;
    base = evq.size();
    wait_now(t_arm + 115);
    check("p5_held_val", evt_val, 1);
    check("p5_cmd_rdy", cmd_rdy, 0);
    first = evt_flowid;
    check("p5_first_flow", 64'(first == 2'd0 || first == 2'd3), 1);
    unstable = 0;
    repeat (20) begin
      tick(1);
      if (!evt_val || evt_flowid != first || evt_reason) unstable++;
    end
    check("p5_stable", 64'(unstable), 0);
    check("p5_none_consumed", 64'(evq.size()), 64'(base));
    evt_rdy = 1'b1;
    tick(10);
    e0 = ev_at(base);
    e1 = ev_at(base + 1);
    check("p5_evt_cnt", 64'(evq.size() - base), 2);
    check("p5_e0_flow", e0.flow, {2'b00, first});
    check("p5_e1_flow", e1.flow, (first == 2'd0) ? 4'd3 : 4'd0);
    check("p5_reasons", {e0.rsn, e1.rsn}, 0);
    check("p5_consecutive", e1.t - e0.t, 1);

    // Reset with a pending event and three armed timers
    cmd(RT_OP_ARM, 2'd3, 32'd0);
    t_arm = acc_now;
    cmd(RT_OP_ARM, 2'd0, 32'd0);
    cmd(RT_OP_ARM, 2'd1, 32'd0);
    cmd(RT_OP_ARM, 2'd2, 32'd0);
    evt_rdy = 1'b0;
    wait_now(t_arm + 110);
    check("p6_pending", evt_val, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("p6_now", now, 0);
    check("p6_evt_val", evt_val, 0);
    check("p6_cmd_rdy", cmd_rdy, 1);
    evt_rdy = 1'b1;
    base = evq.size();
    hiv = 0;
    repeat (220) begin
      tick(1);
      if (evt_val) hiv++;
    end
    check("p6_no_evt_val", 64'(hiv), 0);
    check("p6_no_evt_log", 64'(evq.size()), 64'(base));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
